// File: rtl/sha256_padder.sv
// sha256_padder: collects a byte stream into a 32-word big-endian buffer, appends SHA-256
// padding (0x80, zeros, 64-bit bit length) and exposes the one or two resulting 512-bit
// blocks through a combinational word read port. The buffer is held until msg_done.
// Optional feature macro: SHA256_PADDER_LEN_ERR_EN enables the truncation error flag.
module sha256_padder #(
  parameter int unsigned MAX_BYTES = 119
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic [4:0]  addr,
  output logic [31:0] padded_message,
  output logic        msg_valid,
  output logic        num_blocks,
  input  logic        msg_done,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StPad, StReady} state_e;

  state_e      state_q;
  logic [6:0]  len_q;
  logic [5:0]  wptr_q;
  logic [31:0] buf_q [32];

  logic        accept;
  logic [6:0]  len_inc;
  logic        truncate;
  logic        finish;
  logic [5:0]  pad_end;
  logic [4:0]  wptr_word;
  logic [6:0]  lane_idx;
  logic [31:0] pad_word;

  assign accept    = in_valid & in_ready & (state_q == StIdle);
  assign len_inc   = len_q + 7'd1;
  // Hitting the buffer limit without in_last ends the message anyway.
  assign truncate  = accept & ~in_last & (len_inc == 7'(MAX_BYTES));
  assign finish    = accept & (in_last | (len_inc == 7'(MAX_BYTES)));
  // One past the last word of the final block.
  assign pad_end   = num_blocks ? 6'd32 : 6'd16;
  assign wptr_word = wptr_q[4:0];

  assign padded_message = buf_q[addr];

  // Padded value of the word currently addressed by the PAD pointer.
  always_comb begin
    pad_word = '0;
    lane_idx = '0;
    for (int j = 0; j < 4; j++) begin
      lane_idx = {wptr_word, 2'b00} | 7'(j);
      if (lane_idx < len_q) begin
        pad_word[31 - 8*j -: 8] = buf_q[wptr_word][31 - 8*j -: 8];
      end else if (lane_idx == len_q) begin
        pad_word[31 - 8*j -: 8] = 8'h80;
      end
    end
    if (wptr_word == {num_blocks, 4'he}) begin
      pad_word = '0;
    end else if (wptr_word == {num_blocks, 4'hf}) begin
      pad_word = {22'd0, len_q, 3'b000};
    end
  end

  // Control FSM, byte capture, padding writes and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      wptr_q     <= '0;
      in_ready   <= 1'b1;
      msg_valid  <= 1'b0;
      num_blocks <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            buf_q[len_q[6:2]][(5'd3 - 5'(len_q[1:0])) * 5'd8 +: 8] <= in_data;
            len_q <= len_inc;
            if (finish) begin
              state_q    <= StPad;
              in_ready   <= 1'b0;
              wptr_q     <= {1'b0, len_inc[6:2]};
              num_blocks <= (len_inc > 7'd55);
            end
          end
        end
        StPad: begin
          if (wptr_q == pad_end) begin
            state_q   <= StReady;
            msg_valid <= 1'b1;
          end else begin
            buf_q[wptr_word] <= pad_word;
            wptr_q           <= wptr_q + 6'd1;
          end
        end
        StReady: begin
          if (msg_done) begin
            state_q   <= StIdle;
            msg_valid <= 1'b0;
            in_ready  <= 1'b1;
            len_q     <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef SHA256_PADDER_LEN_ERR_EN
  logic err_q;

  // Sticky truncation flag, released together with the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (truncate) begin
      err_q <= 1'b1;
    end else if ((state_q == StReady) && msg_done) begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  logic unused_truncate;
  assign unused_truncate = truncate;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: directed and random messages compared against a
// byte-level model of SHA-256 padding.
module tb_sha256_padder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic [4:0]  addr;
  logic [31:0] padded_message;
  logic        msg_valid;
  logic        num_blocks;
  logic        msg_done;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [7:0] msg [128];

`ifdef SHA256_PADDER_LEN_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  sha256_padder dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_last        (in_last),
    .in_ready       (in_ready),
    .addr           (addr),
    .padded_message (padded_message),
    .msg_valid      (msg_valid),
    .num_blocks     (num_blocks),
    .msg_done       (msg_done),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte i of the padded message of length len: data, 0x80, zeros, 64-bit big-endian length.
  function automatic logic [7:0] model_byte(input int i, input int len);
    int total;
    longint unsigned bits;
    total = (len <= 55) ? 64 : 128;
    bits  = longint'(len) * 8;
    if (i < len) return msg[i];
    if (i == len) return 8'h80;
    if (i >= total - 8) return 8'(bits >> (8 * (total - 1 - i)));
    return 8'h00;
  endfunction

  function automatic logic [31:0] model_word(input int w, input int len);
    return {model_byte(4*w, len), model_byte(4*w + 1, len),
            model_byte(4*w + 2, len), model_byte(4*w + 3, len)};
  endfunction

  task automatic read_word(input int w, input logic [31:0] exp, input string tag);
    addr = 5'(w);
    #1;
    chk(tag, padded_message, exp);
  endtask

  task automatic send(input int n, input bit use_last);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = msg[k];
      in_last  = use_last && (k == n - 1);
      chk("in_ready_offer", 32'(in_ready), (k < 119) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("in_ready_after_last", 32'(in_ready), 32'd0);
  endtask

  // len: accepted bytes; offered: bytes driven; extra offers after truncation eat cycles.
  task automatic check_msg(input int len, input int offered, input bit done_in_pad,
                           input bit exp_err);
    int nb;
    int n_pad;
    int cyc;
    nb    = (len <= 55) ? 1 : 2;
    n_pad = 16 * nb - len / 4;
    cyc   = 0;
    if (done_in_pad) begin
      msg_done = 1'b1;
      @(posedge clk);
      #1;
      msg_done = 1'b0;
      cyc = 1;
    end
    while (!msg_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(n_pad + 1 - (offered - len)));
    chk("msg_valid", 32'(msg_valid), 32'd1);
    chk("num_blocks", 32'(num_blocks), 32'(nb - 1));
    chk("err", 32'(err), 32'(exp_err));
    chk("in_ready_ready", 32'(in_ready), 32'd0);
    for (int w = 0; w < 16 * nb; w++) begin
      read_word(w, model_word(w, len), "word");
    end
  endtask

  task automatic release_msg();
    msg_done = 1'b1;
    @(posedge clk);
    #1;
    msg_done = 1'b0;
    chk("msg_valid_released", 32'(msg_valid), 32'd0);
    chk("in_ready_released", 32'(in_ready), 32'd1);
    chk("err_released", 32'(err), 32'd0);
  endtask

  initial begin
    int len;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    addr     = 5'd0;
    msg_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_msg_valid", 32'(msg_valid), 32'd0);
    chk("rst_num_blocks", 32'(num_blocks), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    for (int w = 0; w < 32; w++) read_word(w, 32'd0, "rst_word");

    // "abc"
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send(3, 1'b1);
    check_msg(3, 3, 1'b0, 1'b0);
    read_word(0, 32'h61626380, "abc_word0");
    read_word(15, 32'h00000018, "abc_word15");
    release_msg();

    // 55 and 56 bytes: one/two block boundary
    for (int k = 0; k < 128; k++) msg[k] = 8'h41;
    send(55, 1'b1);
    check_msg(55, 55, 1'b0, 1'b0);
    read_word(13, 32'h41414180, "l55_word13");
    read_word(15, 32'h000001b8, "l55_word15");
    release_msg();

    send(56, 1'b1);
    check_msg(56, 56, 1'b0, 1'b0);
    read_word(14, 32'h80000000, "l56_word14");
    read_word(31, 32'h000001c0, "l56_word31");
    release_msg();

    // 120 bytes without in_last: truncated to 119
    send(120, 1'b0);
    check_msg(119, 120, 1'b0, ErrEn);
    read_word(29, 32'h41414180, "trunc_word29");
    read_word(31, 32'h000003b8, "trunc_word31");
    release_msg();

    // Random messages; one carries a msg_done pulse during PAD
    for (int r = 0; r < 8; r++) begin
      len = int'($urandom_range(1, 119));
      for (int k = 0; k < len; k++) msg[k] = 8'($urandom);
      send(len, 1'b1);
      check_msg(len, len, r == 2, 1'b0);
      release_msg();
    end

    // New message right after release (previous release above), msg_done during PAD ignored
    msg[0] = 8'h00;
    send(1, 1'b1);
    check_msg(1, 1, 1'b1, 1'b0);
    read_word(0, 32'h00800000, "one_word0");
    read_word(15, 32'h00000008, "one_word15");
    release_msg();

    // Reset on the 5th PAD cycle
    for (int k = 0; k < 128; k++) msg[k] = 8'h5a;
    send(3, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("padrst_in_ready", 32'(in_ready), 32'd1);
    chk("padrst_msg_valid", 32'(msg_valid), 32'd0);
    chk("padrst_err", 32'(err), 32'd0);
    for (int w = 0; w < 32; w++) read_word(w, 32'd0, "padrst_word");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_padder.md
# sha256_padder

Upstream message-preparation stage for the SHA-256 core. Accepts a byte stream per message, stores it big-endian in a 32-word buffer, and appends SHA-256 padding: 0x80, zeros, and the 64-bit bit length. It then presents one or two 512-bit blocks to the core as a combinational word read port addressed by the core's 5-bit `addr`. The buffer is held until the core signals completion.

## Interface
Parameters:
- MAX_BYTES, 119: longest message accepted; fixed by the 2-block buffer; not to be overridden.

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  byte on `in_data` is offered
- in_data  in  8  message byte
- in_last  in  1  qualifies the final byte of the message
- in_ready  out  1  byte accepted when `in_valid & in_ready`
- addr  in  5  word index from core; 0–15 = block 0, 16–31 = block 1
- padded_message  out  32  buffer word at `addr`
- msg_valid  out  1  padded message complete and stable
- num_blocks  out  1  0 = one block, 1 = two blocks; valid while `msg_valid`
- msg_done  in  1  core finished; releases buffer
- err  out  1  length overflow flag (see Configuration)

## Operation
- States: IDLE, PAD, READY.
- IDLE: `in_ready` = 1. Each accepted byte number k (0-based) is written to word k/4, lane bits [31−8·(k%4) −: 8]. The byte counter L increments.
- Accepting a byte with `in_last` = 1 latches the final length L (1..119) and enters PAD.
- Accepting byte 119 with `in_last` = 0 truncates: L = 119, and the block enters PAD as if `in_last` had been set. Further bytes are not accepted until READY completes.
- Block count: nb = 1 if L ≤ 55, else 2; `num_blocks` = nb − 1.
- PAD writes one word per cycle, for w = floor(L/4) up to 16·nb − 1:
  - Message lanes below L%4 in word floor(L/4) are preserved.
  - Byte L = 0x80.
  - All other bytes are 0x00.
  - Word 16·nb − 2 = 0.
  - Word 16·nb − 1 = L·8, zero-extended (maximum 952).
- READY: `msg_valid` = 1 and the buffer is frozen.
  - `msg_done` = 1 clears `msg_valid` and `err`, sets L = 0, and returns to IDLE.
  - `msg_done` is ignored in IDLE and PAD.
- Words beyond 16·nb − 1 are don't-care; the core must not read them when nb = 1.
- Zero-length messages are unsupported: `in_last` always accompanies a byte.
- `padded_message` = buf[addr], purely combinational from the registered buffer. This holds in all states.

## Timing
- Reset values: state IDLE, L = 0, all 32 buffer words = 0, `padded_message` = 0, `in_ready` = 1, `msg_valid` = 0, `num_blocks` = 0, `err` = 0.
- Last byte accepted at edge T: PAD writes occur at edges T+1 … T+N, where N = 16·nb − floor(L/4). `msg_valid` = 1 after edge T+N+1. `in_ready` = 0 from after edge T.
- `msg_done` sampled at edge R while READY: `msg_valid` = 0 and `in_ready` = 1 after R. A byte may be accepted at edge R+1.
- `in_valid` and `in_last` are ignored while `in_ready` = 0.
- `rst` asserted in any state, including mid-PAD or mid-stream, returns all state to reset values at that edge. It overrides a simultaneous byte acceptance or `msg_done`.
- Read latency: zero cycles (combinational) from `addr` to `padded_message`.

## Configuration
- `SHA256_PADDER_LEN_ERR_EN` defined: a truncation (byte 119 accepted without `in_last`) sets `err` = 1 at that edge. `err` remains 1 through PAD and READY, and is cleared by `msg_done` or `rst`. Padding is still performed on the truncated 119 bytes.
- Not defined: truncation behaves identically, but `err` is tied to 0 and no error logic is built.

## Test plan
- "abc" (0x61,0x62,0x63, last on 3rd byte) -> 16 PAD cycles. Then `msg_valid` = 1, `num_blocks` = 0, word0 = 0x61626380, words 1–14 = 0, word15 = 0x00000018.
- 55 bytes of 0x41 -> `num_blocks` = 0. Word13 = 0x41414180, word14 = 0, word15 = 0x000001B8.
- 56 bytes of 0x41 -> `num_blocks` = 1. Word14 = 0x80000000, words 15–29 = 0, word30 = 0, word31 = 0x000001C0.
- 120 bytes offered without `in_last` -> `in_ready` drops after byte 119. Word29 = 0x41414180, word31 = 0x000003B8. `err` = 1 with the macro defined, 0 without.
- `msg_done` pulse in READY, then immediately a new 1-byte message 0x00 -> old contents replaced. Word0 = 0x00800000, word15 = 0x00000008. A `msg_done` pulse issued during PAD has no effect.
- `rst` asserted on the 5th PAD cycle -> next cycle: IDLE, `in_ready` = 1, `msg_valid` = 0, all words read 0.
